interp_tap_sum: RTL



---
 rtl/interp_tap_sum.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/interp_tap_sum.sv
// Interpolation tap summation stage: applies the fixed tap sign pattern to
// eight MCM product magnitudes, sums them through a 4-stage pipelined adder
// tree, then rounds, normalises and (optionally) clips to the sample range.
// All stages advance together on en = !out_valid || out_ready.
module interp_tap_sum #(
   parameter int             IN_W      = 32,
   parameter int             SUM_W     = 36,
   parameter int             SHIFT     = 6,
   parameter int             BITDEPTH  = 10,
   parameter int             CLIP      = 1,
   parameter int             OUT_W     = 16,
   parameter logic [7:0]     SIGN_MASK = 8'b10100101
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   p0,
   input  logic [IN_W-1:0]   p1,
   input  logic [IN_W-1:0]   p2,
   input  logic [IN_W-1:0]   p3,
   input  logic [IN_W-1:0]   p4,
   input  logic [IN_W-1:0]   p5,
   input  logic [IN_W-1:0]   p6,
   input  logic [IN_W-1:0]   p7,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_sample
);

   // Rounding offset is half an output LSB; it vanishes when there is no shift.
   localparam logic signed [SUM_W-1:0] RND   = SUM_W'((64'd1 << SHIFT) >> 1);
   localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((64'd1 << BITDEPTH) - 64'd1);

   // Sign-extend one product to the accumulator width and apply its tap sign.
   function automatic logic signed [SUM_W-1:0] signed_term(
      input logic [IN_W-1:0] mag,
      input logic            neg
   );
      logic signed [SUM_W-1:0] ext;
      ext = SUM_W'($signed(mag));
      if (neg) begin
         signed_term = -ext;
      end else begin
         signed_term = ext;
      end
   endfunction

   logic                    en_s;
   logic [IN_W-1:0]         p_s [8];
   logic signed [SUM_W-1:0] pair_s [4];
   logic signed [SUM_W-1:0] s1_t_r [4];
   logic signed [SUM_W-1:0] s2_a_r;
   logic signed [SUM_W-1:0] s2_b_r;
   logic signed [SUM_W-1:0] s3_tot_r;
   logic signed [SUM_W-1:0] sh_s;
   logic [OUT_W-1:0]        res_s;
   logic                    v1_r;
   logic                    v2_r;
   logic                    v3_r;

   assign en_s     = !out_valid || out_ready;
   assign in_ready = en_s;

   assign p_s[0] = p0;
   assign p_s[1] = p1;
   assign p_s[2] = p2;
   assign p_s[3] = p3;
   assign p_s[4] = p4;
   assign p_s[5] = p5;
   assign p_s[6] = p6;
   assign p_s[7] = p7;

   // Form the four signed pair terms feeding the first register stage.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         pair_s[k] = signed_term(p_s[2*k], SIGN_MASK[2*k])
                   + signed_term(p_s[2*k+1], SIGN_MASK[2*k+1]);
      end
   end

   // Stage 1: capture pair terms on an accepted input.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v1_r <= 1'b0;
         for (int k = 0; k < 4; k++) begin
            s1_t_r[k] <= {SUM_W{1'b0}};
         end
      end else if (en_s) begin
         v1_r <= in_valid;
         if (in_valid) begin
            for (int k = 0; k < 4; k++) begin
               s1_t_r[k] <= pair_s[k];
            end
         end
      end
   end

   // Stage 2: reduce four pair terms to two partial sums.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v2_r   <= 1'b0;
         s2_a_r <= {SUM_W{1'b0}};
         s2_b_r <= {SUM_W{1'b0}};
      end else if (en_s) begin
         v2_r <= v1_r;
         if (v1_r) begin
            s2_a_r <= s1_t_r[0] + s1_t_r[1];
            s2_b_r <= s1_t_r[2] + s1_t_r[3];
         end
      end
   end

   // Stage 3: final total with the rounding offset folded in.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v3_r     <= 1'b0;
         s3_tot_r <= {SUM_W{1'b0}};
      end else if (en_s) begin
         v3_r <= v2_r;
         if (v2_r) begin
            s3_tot_r <= s2_a_r + s2_b_r + RND;
         end
      end
   end

   // Normalise with a flooring arithmetic shift, then clip or truncate.
   always_comb begin
      sh_s  = s3_tot_r >>> SHIFT;
      res_s = OUT_W'(sh_s);
      if (CLIP != 0) begin
         if (sh_s[SUM_W-1]) begin
            res_s = {OUT_W{1'b0}};
         end else if (sh_s > MAX_V) begin
            res_s = OUT_W'(MAX_V);
         end else begin
            res_s = OUT_W'(sh_s);
         end
      end else begin
         res_s = OUT_W'(sh_s);
      end
   end

   // Stage 4: registered output sample and its valid flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_sample <= {OUT_W{1'b0}};
      end else if (en_s) begin
         out_valid <= v3_r;
         if (v3_r) begin
            out_sample <= res_s;
         end
      end
   end

endmodule
